// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state type and segment codes for the display scanner
package seg_pkg;

  typedef enum logic {BLANK, SHOW} state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - digit/control inputs and multiplexed display outputs
interface seg_scan_if;
  logic       en;
  logic       lzb;
  logic [3:0] dp_sel;
  logic [3:0] one;
  logic [3:0] ten;
  logic [3:0] hun;
  logic [3:0] thoud;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, lzb, dp_sel, one, ten, hun, thoud,
    input  an, seg, dp
  );

  modport slave (
    input  en, lzb, dp_sel, one, ten, hun, thoud,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-low seven-segment pattern
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit time-multiplexed display driver with guard blanking,
// frame snapshot, leading-zero suppression and decimal points
module seg_scan
  import seg_pkg::*;
#(
  parameter int DWELL = 3,
  parameter int GUARD = 1
) (
  input  logic       msclk,
  input  logic       reset,
  seg_scan_if.slave  bus
);

  localparam int TMAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [1:0]      idx, idx_nx;
  logic            take;

  logic [3:0][3:0] snap_dig, snap_dig_nx;
  logic            snap_lzb, snap_lzb_nx;
  logic [3:0]      snap_dp, snap_dp_nx;

  logic [3:0]      zero_ok;
  logic [3:0]      lead_blank;
  logic            lit;
  logic [6:0]      dec;

  logic [3:0]      an_q, an_nx;
  logic [6:0]      seg_q, seg_nx;
  logic            dp_q, dp_nx;

  always_ff @(posedge msclk) begin
    if (reset) begin
      state    <= BLANK;
      timer    <= '0;
      idx      <= '0;
      snap_dig <= '0;
      snap_lzb <= 1'b0;
      snap_dp  <= '0;
      an_q     <= 4'hF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      idx      <= idx_nx;
      snap_dig <= snap_dig_nx;
      snap_lzb <= snap_lzb_nx;
      snap_dp  <= snap_dp_nx;
      an_q     <= an_nx;
      seg_q    <= seg_nx;
      dp_q     <= dp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer + TW'(1);
    idx_nx   = idx;
    take     = 1'b0;
    case (state)
      BLANK: begin
        if (timer == TW'(GUARD - 1)) begin
          state_nx = SHOW;
          timer_nx = '0;
          take     = (idx == 2'd0);
        end
      end
      SHOW: begin
        if (timer == TW'(DWELL - 1)) begin
          state_nx = BLANK;
          timer_nx = '0;
          idx_nx   = idx + 2'd1;
        end
      end
      default: begin
        state_nx = BLANK;
        timer_nx = '0;
      end
    endcase
  end

  // Outputs are registered from the next-cycle view, so the snapshot taken on this
  // edge must already drive the slot-0 decode.
  always_comb begin
    snap_dig_nx = take ? {bus.thoud, bus.hun, bus.ten, bus.one} : snap_dig;
    snap_lzb_nx = take ? bus.lzb : snap_lzb;
    snap_dp_nx  = take ? bus.dp_sel : snap_dp;

    zero_ok = '0;
    for (int k = 0; k < 4; k++) begin
      zero_ok[k] = (snap_dig_nx[k] == 4'd0) && !snap_dp_nx[k];
    end
    lead_blank    = '0;
    lead_blank[3] = snap_lzb_nx & zero_ok[3];
    lead_blank[2] = lead_blank[3] & zero_ok[2];
    lead_blank[1] = lead_blank[2] & zero_ok[1];

    lit   = (state_nx == SHOW) && bus.en && !lead_blank[idx_nx];
    an_nx = lit ? ~(4'b0001 << idx_nx) : 4'hF;
    seg_nx = lit ? dec : SEG_OFF;
    dp_nx  = lit ? ~snap_dp_nx[idx_nx] : 1'b1;
  end

  bcd_to_seg u_dec (
    .bcd (snap_dig_nx[idx_nx]),
    .seg (dec)
  );

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
